plru_ctrl: RTL and testbench
============================

Name: plru_ctrl

Overview:
- Tree pseudo-LRU replacement controller for set-associative caches; successor to the fixed per-set PLRU tracker.
- Generalised to any power-of-two WAYS ≥ 2, with asynchronous reset, a flush sweep FSM and invalid-way-first victim selection.
- Lookups use a valid/ready handshake and produce a registered victim.
- Sits beside the tag/data arrays in the cache controller. Lookups happen on a miss; touches happen on a hit or fill.

Parameters:
- SETS, 8, number of sets; must be a power of two ≥ 2.
- WAYS, 4, associativity; must be a power of two ≥ 2. The tree has WAYS-1 bits per set.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pulse; starts a sweep that clears every tree
- busy  out  1  high while the flush sweep runs
- lookup_valid  in  1  victim request
- lookup_ready  out  1  request accepted when valid && ready
- lookup_index  in  $clog2(SETS)  set index of the request
- lookup_way_valid  in  WAYS  per-way valid bits of the requested set
- victim_valid  out  1  one-cycle pulse; victim_way is valid
- victim_way  out  $clog2(WAYS)  chosen victim way
- touch  in  1  mark a way as most recently used
- touch_index  in  $clog2(SETS)  set index of the touch
- touch_way  in  $clog2(WAYS)  way being touched

Behaviour:
- Reset (asynchronous, active-low):
  - All tree bits = 0.
  - FSM state = READY.
  - busy = 0, victim_valid = 0, victim_way = 0.
  - Clock domain: clk only; rst_n is asserted asynchronously, deasserted synchronously upstream.
- Tree encoding:
  - Node 0 is the root; the children of node n are 2n+1 (lower half of ways) and 2n+2 (upper half).
  - A node bit of 0 means the victim lies in the lower half; 1 means the upper half.
- Touch (when touch = 1 and state = READY):
  - Every node on the path to touch_way is set to point away from it.
  - Off-path nodes are unchanged.
  - Takes effect at the next clock edge.
- Lookup:
  - lookup_ready = (state == READY).
  - On handshake, victim_way is registered and victim_valid pulses exactly 1 cycle later.
  - Back-to-back lookups are accepted every cycle.
- Victim rule:
  - If any bit of lookup_way_valid is 0, the victim is the lowest-index invalid way.
  - Otherwise, walk the tree from the root to a leaf.
- Same-cycle touch and lookup:
  - Same index: write-first forwarding; the lookup uses the tree after the touch is applied.
  - Different indices: independent.
- A lookup does not modify the tree. The requester issues a touch when the fill completes.
- FSM states:
  - READY: flush = 1 → SWEEP. The sweep counter loads 0, and busy rises the next cycle.
  - SWEEP: clears the tree at counter index each cycle and increments the counter. After index SETS-1 → READY. The sweep takes SETS cycles exactly.
- During SWEEP:
  - lookup_ready = 0; touch is ignored (dropped, not queued).
  - flush is ignored; no restart.
- flush and touch in the same READY cycle: the touch is dropped, the flush wins.
- Async reset during SWEEP aborts it: state returns to READY with all trees already cleared.
- A lookup handshake in the same cycle flush is sampled is still completed: victim_valid fires the next cycle using the pre-flush tree.
- Counter width: $clog2(SETS); it wraps to 0 only on exit.

Optional Feature:
- Macro PLRU_WAY_LOCK_EN.
- When defined:
  - Adds input lock_mask [WAYS-1:0].
  - Locked ways are never chosen as victim. At each tree node, if every way in the preferred subtree is locked, the walk takes the other subtree.
  - If all ways are locked, victim_way = 0 and the extra output victim_none = 1 is pulsed alongside victim_valid.
  - Invalid-way-first selection also skips locked ways.
- When undefined: neither port exists and behaviour is as above.

Decomposition:
- Package plru_pkg:
  - FSM state enum (PLRU_READY, PLRU_SWEEP).
  - Functions plru_victim(tree, mask) and plru_update(tree, way), parametrised by WAYS through sized function arguments.
- Sub-module plru_tree_walk: combinational victim selection for one tree. Instantiated once for the lookup path; the forwarding mux sits before it.

Test Plan (WAYS = 4, SETS = 8 unless stated):
- Reset, lookup index 3 with all ways valid → victim_valid one cycle later, victim_way = 0.
- Touches 0, 2, 1 on index 5, each followed by a lookup:
  - after touch 0 → victim 2
  - after touch 2 → victim 1
  - after touch 1 → victim 3
- lookup_way_valid = 4'b1011 → victim 2, regardless of tree state. Value 4'b0000 → victim 0.
- Same-cycle touch way 0 and lookup on index 1 (fresh tree) → victim 2 (forwarding). A lookup to index 2 in the same cycle → victim 0.
- Touch index 7 way 0, then flush:
  - busy high for 8 cycles; lookup_ready = 0 and a touch issued mid-sweep is dropped.
  - Afterwards, lookup index 7 → victim 0.
- With PLRU_WAY_LOCK_EN, after reset:
  - lock_mask = 4'b0011 → victim 2.
  - lock_mask = 4'b1111 → victim_none = 1, victim_way = 0.

Source files
------------

// File: rtl/plru_pkg.sv
// plru_pkg: shared types and tree functions for the pseudo-LRU controller.
//   plru_state_e : sweep FSM states.
//   plru_victim  : walk a tree (with optional lock mask) to a victim leaf.
//   plru_update  : point every node on a way's path away from that way.
// The functions work on trees padded to PLRU_MAX_WAYS; callers pass the
// real depth (log2 of WAYS) and zero-extend / truncate around the call.
// Optional feature macro used by the design: PLRU_WAY_LOCK_EN.
package plru_pkg;

  typedef enum logic {
    PLRU_READY = 1'b0,
    PLRU_SWEEP = 1'b1
  } plru_state_e;

  localparam int PLRU_MAX_LVL  = 6;
  localparam int PLRU_MAX_WAYS = 1 << PLRU_MAX_LVL;

  typedef logic [PLRU_MAX_WAYS-2:0] plru_tree_t;
  typedef logic [PLRU_MAX_WAYS-1:0] plru_mask_t;
  typedef logic [PLRU_MAX_LVL-1:0]  plru_way_t;

  typedef struct packed {
    logic      none;
    plru_way_t way;
  } plru_pick_t;

  // True when every way whose index shifted right by 'shift' equals 'prefix'
  // is locked, i.e. the whole subtree rooted at that prefix is unusable.
  function automatic logic plru_all_locked(plru_mask_t lock, plru_way_t prefix,
                                           int shift, int ways);
    logic       all;
    plru_mask_t sh;
    all = 1'b1;
    for (int i = 0; i < PLRU_MAX_WAYS; i++) begin
      sh = lock >> i;
      if (i < ways && (i >> shift) == int'(prefix) && !sh[0]) all = 1'b0;
    end
    return all;
  endfunction

  function automatic plru_pick_t plru_victim(plru_tree_t tree, plru_mask_t lock, int lvls);
    plru_pick_t pick;
    plru_way_t  n;
    plru_way_t  pre;
    logic       b;
    int         ways;
    ways = 1 << lvls;
    pick = '0;
    n    = '0;
    if (plru_all_locked(lock, '0, lvls, ways)) begin
      pick.none = 1'b1;
    end else begin
      for (int l = 0; l < PLRU_MAX_LVL; l++) begin
        if (l < lvls) begin
          b   = tree[n];
          pre = {pick.way[PLRU_MAX_LVL-2:0], b};
          // Preferred half fully locked: take the sibling instead.
          if (plru_all_locked(lock, pre, lvls - 1 - l, ways)) b = ~b;
          pick.way = {pick.way[PLRU_MAX_LVL-2:0], b};
          n = (n << 1) + plru_way_t'(1) + plru_way_t'(b);
        end
      end
    end
    return pick;
  endfunction

  function automatic plru_tree_t plru_update(plru_tree_t tree, plru_way_t way, int lvls);
    plru_tree_t t;
    plru_way_t  n;
    plru_way_t  sh;
    logic       b;
    t = tree;
    n = '0;
    for (int l = 0; l < PLRU_MAX_LVL; l++) begin
      if (l < lvls) begin
        sh   = way >> (lvls - 1 - l);
        b    = sh[0];
        t[n] = ~b;
        n    = (n << 1) + plru_way_t'(1) + plru_way_t'(b);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/plru_ctrl_tree_walk.sv
// plru_tree_walk: combinational victim choice for one PLRU tree.
//   tree_i      : WAYS-1 node bits (heap order, node 0 = root)
//   way_valid_i : per-way valid bits; lowest invalid, unlocked way wins
//   lock_i      : ways that must never be chosen (all zero when unused)
//   victim_o    : chosen way
//   none_o      : every way locked; victim_o is then 0
// Works with the PLRU_WAY_LOCK_EN feature of plru_ctrl through lock_i.
module plru_tree_walk
  import plru_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         tree_i,
  input  logic [WAYS-1:0]         way_valid_i,
  input  logic [WAYS-1:0]         lock_i,
  output logic [$clog2(WAYS)-1:0] victim_o,
  output logic                    none_o
);

  localparam int LW = $clog2(WAYS);

  plru_tree_t      tree_x;
  plru_mask_t      lock_x;
  plru_pick_t      pick;
  logic [WAYS-1:0] cand;
  logic [WAYS-1:0] one;

  always_comb begin
    tree_x             = '0;
    tree_x[WAYS-2:0]   = tree_i;
    lock_x             = '0;
    lock_x[WAYS-1:0]   = lock_i;
    pick               = plru_victim(tree_x, lock_x, LW);
    victim_o           = pick.way[LW-1:0];
    none_o             = pick.none;
    cand               = ~way_valid_i & ~lock_i;
    one                = {{(WAYS-1){1'b0}}, 1'b1};
    // Descending scan so the lowest-index candidate is the last to win.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if ((cand & (one << i)) != '0) victim_o = LW'(i);
    end
  end

endmodule

// File: rtl/plru_ctrl.sv
// plru_ctrl: per-set tree pseudo-LRU replacement controller.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush / busy          : start / progress of the SETS-cycle clearing sweep
//   lookup_valid/_ready   : victim request handshake (ready only in READY)
//   lookup_index          : set of the request
//   lookup_way_valid      : valid bits of that set (invalid ways win first)
//   victim_valid/_way     : registered result, one cycle after handshake
//   touch/_index/_way     : mark a way most recently used
// Optional macro PLRU_WAY_LOCK_EN adds lock_mask (ways never evicted) and
// victim_none (pulsed with victim_valid when every way is locked).
module plru_ctrl
  import plru_pkg::*;
#(
  parameter int SETS = 8,
  parameter int WAYS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef PLRU_WAY_LOCK_EN
  input  logic [WAYS-1:0]         lock_mask,
  output logic                    victim_none,
`endif
  input  logic                    flush,
  output logic                    busy,
  input  logic                    lookup_valid,
  output logic                    lookup_ready,
  input  logic [$clog2(SETS)-1:0] lookup_index,
  input  logic [WAYS-1:0]         lookup_way_valid,
  output logic                    victim_valid,
  output logic [$clog2(WAYS)-1:0] victim_way,
  input  logic                    touch,
  input  logic [$clog2(SETS)-1:0] touch_index,
  input  logic [$clog2(WAYS)-1:0] touch_way
);

  localparam int LW = $clog2(WAYS);
  localparam int IW = $clog2(SETS);
  localparam int TW = WAYS - 1;

  plru_state_e     state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tree_q [SETS];
  logic            victim_valid_q;
  logic [LW-1:0]   victim_way_q;
  logic            victim_none_q;

  logic            touch_en;
  logic            lookup_fire;
  logic [TW-1:0]   touch_tree;
  logic [TW-1:0]   walk_tree;
  logic [LW-1:0]   walk_way;
  logic            walk_none;
  logic [WAYS-1:0] lock_w;
  plru_tree_t      tree_x;
  plru_tree_t      upd_x;
  plru_way_t       way_x;

`ifdef PLRU_WAY_LOCK_EN
  assign lock_w      = lock_mask;
  assign victim_none = victim_none_q;
`else
  assign lock_w = '0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLRU_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; flush during the sweep is ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PLRU_READY: begin
        if (flush) begin
          state_d = PLRU_SWEEP;
          cnt_d   = '0;
        end
      end
      PLRU_SWEEP: begin
        if (cnt_q == IW'(SETS - 1)) begin
          state_d = PLRU_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      default: state_d = PLRU_READY;
    endcase
  end

  // FSM outputs
  always_comb begin
    lookup_ready = (state_q == PLRU_READY);
    busy         = (state_q == PLRU_SWEEP);
  end

  // A touch in the same cycle as flush is dropped in favour of the sweep.
  assign touch_en    = touch && (state_q == PLRU_READY) && !flush;
  assign lookup_fire = lookup_valid && lookup_ready;

  always_comb begin
    tree_x           = '0;
    tree_x[TW-1:0]   = tree_q[touch_index];
    way_x            = '0;
    way_x[LW-1:0]    = touch_way;
    upd_x            = plru_update(tree_x, way_x, LW);
    touch_tree       = upd_x[TW-1:0];
  end

  // Write-first: a same-set touch is visible to the lookup in the same cycle.
  assign walk_tree = (touch_en && touch_index == lookup_index) ? touch_tree
                                                               : tree_q[lookup_index];

  plru_tree_walk #(.WAYS(WAYS)) u_walk (
    .tree_i      (walk_tree),
    .way_valid_i (lookup_way_valid),
    .lock_i      (lock_w),
    .victim_o    (walk_way),
    .none_o      (walk_none)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else if (state_q == PLRU_SWEEP) begin
      tree_q[cnt_q] <= '0;
    end else if (touch_en) begin
      tree_q[touch_index] <= touch_tree;
    end
  end

  // Registered victim; way is held between handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_none_q  <= 1'b0;
    end else begin
      victim_valid_q <= lookup_fire;
      if (lookup_fire) begin
        victim_way_q  <= walk_none ? '0 : walk_way;
        victim_none_q <= walk_none;
      end
    end
  end

  assign victim_valid = victim_valid_q;
  assign victim_way   = victim_way_q;

endmodule

// File: tb/tb_plru_ctrl.sv
// Self-checking bench for plru_ctrl (WAYS=4, SETS=8): directed steps from the
// feature list followed by randomized traffic checked against a range-halving
// reference model. Build with PLRU_WAY_LOCK_EN to also exercise lock_mask.
module tb_plru_ctrl;

  localparam int SETS = 8;
  localparam int WAYS = 4;
  localparam int LW   = 2;
  localparam int IW   = 3;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            busy;
  logic            lookup_valid;
  logic            lookup_ready;
  logic [IW-1:0]   lookup_index;
  logic [WAYS-1:0] lookup_way_valid;
  logic            victim_valid;
  logic [LW-1:0]   victim_way;
  logic            touch;
  logic [IW-1:0]   touch_index;
  logic [LW-1:0]   touch_way;
`ifdef PLRU_WAY_LOCK_EN
  logic [WAYS-1:0] lock_mask;
  logic            victim_none;
`endif

  plru_ctrl #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
`ifdef PLRU_WAY_LOCK_EN
    .lock_mask        (lock_mask),
    .victim_none      (victim_none),
`endif
    .flush            (flush),
    .busy             (busy),
    .lookup_valid     (lookup_valid),
    .lookup_ready     (lookup_ready),
    .lookup_index     (lookup_index),
    .lookup_way_valid (lookup_way_valid),
    .victim_valid     (victim_valid),
    .victim_way       (victim_way),
    .touch            (touch),
    .touch_index      (touch_index),
    .touch_way        (touch_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: node bits per set, remaining sweep cycles, sweep pointer.
  bit mt [SETS][WAYS-1];
  int m_rem = 0;
  int m_idx = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_clear_all();
    for (int s = 0; s < SETS; s++)
      for (int n = 0; n < WAYS - 1; n++) mt[s][n] = 1'b0;
  endtask

  function automatic bit m_locked(bit [WAYS-1:0] lk, int lo, int hi);
    for (int i = lo; i < hi; i++) if (!lk[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Victim from the rules: unlocked invalid way first, else halve the way
  // range following node bits, steering around fully locked halves.
  function automatic int m_victim(int s, bit [WAYS-1:0] vld, bit [WAYS-1:0] lk,
                                  output bit none);
    int lo, hi, mid, node;
    bit up;
    none = 1'b0;
    for (int w = 0; w < WAYS; w++) if (!vld[w] && !lk[w]) return w;
    if (m_locked(lk, 0, WAYS)) begin
      none = 1'b1;
      return 0;
    end
    lo = 0; hi = WAYS; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      up  = mt[s][node];
      if (up && m_locked(lk, mid, hi)) up = 1'b0;
      else if (!up && m_locked(lk, lo, mid)) up = 1'b1;
      if (up) begin lo = mid; node = 2 * node + 2; end
      else    begin hi = mid; node = 2 * node + 1; end
    end
    return lo;
  endfunction

  task automatic m_touch(int s, int w);
    int lo, hi, mid, node;
    lo = 0; hi = WAYS; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin mt[s][node] = 1'b1; hi = mid; node = 2 * node + 1; end
      else         begin mt[s][node] = 1'b0; lo = mid; node = 2 * node + 2; end
    end
  endtask

  task automatic idle_inputs();
    flush = 0; lookup_valid = 0; lookup_index = '0; lookup_way_valid = '1;
    touch = 0; touch_index = '0; touch_way = '0;
`ifdef PLRU_WAY_LOCK_EN
    lock_mask = '0;
`endif
  endtask

  // One clock cycle: drive, predict, clock, check after the edge.
  task automatic step(bit lv, int li, bit [WAYS-1:0] lwv, bit t, int ti, int tw,
                      bit fl, bit [WAYS-1:0] lk);
    bit ready_m, fire, none_m;
    int way_m;
    lookup_valid = lv; lookup_index = IW'(li); lookup_way_valid = lwv;
    touch = t; touch_index = IW'(ti); touch_way = LW'(tw); flush = fl;
`ifdef PLRU_WAY_LOCK_EN
    lock_mask = lk;
`endif
    ready_m = (m_rem == 0);
    fire    = lv && ready_m;
    way_m   = 0;
    none_m  = 1'b0;
    if (t && ready_m && !fl) m_touch(ti, tw);
    if (fire) way_m = m_victim(li, lwv, lk, none_m);
    if (m_rem > 0) begin
      for (int n = 0; n < WAYS - 1; n++) mt[m_idx][n] = 1'b0;
      m_idx++;
      m_rem--;
    end else if (fl) begin
      m_rem = SETS;
      m_idx = 0;
    end
    @(posedge clk);
    #1;
    chk("victim_valid", victim_valid, fire);
    if (fire) begin
      chk("victim_way", victim_way, way_m);
`ifdef PLRU_WAY_LOCK_EN
      chk("victim_none", victim_none, none_m);
`endif
    end
    chk("busy", busy, m_rem > 0);
    chk("lookup_ready", lookup_ready, m_rem == 0);
  endtask

  initial begin : main
    bit [WAYS-1:0] allv;
    bit [WAYS-1:0] nolk;
    int busy_cnt;
    allv = '1;
    nolk = '0;
    idle_inputs();
    rst_n = 1'b0;
    m_clear_all();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_victim_valid", victim_valid, 0);
    chk("rst_victim_way", victim_way, 0);
    chk("rst_lookup_ready", lookup_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh tree
    step(1, 3, allv, 0, 0, 0, 0, nolk);
    chk("fresh_idx3", victim_way, 0);

    // Touch sequence on set 5
    step(0, 0, allv, 1, 5, 0, 0, nolk);
    step(1, 5, allv, 0, 0, 0, 0, nolk);
    chk("after_touch0", victim_way, 2);
    step(0, 0, allv, 1, 5, 2, 0, nolk);
    step(1, 5, allv, 0, 0, 0, 0, nolk);
    chk("after_touch2", victim_way, 1);
    step(0, 0, allv, 1, 5, 1, 0, nolk);
    step(1, 5, allv, 0, 0, 0, 0, nolk);
    chk("after_touch1", victim_way, 3);

    // Invalid ways take priority
    step(1, 5, 4'b1011, 0, 0, 0, 0, nolk);
    chk("invalid_way2", victim_way, 2);
    step(1, 5, 4'b0000, 0, 0, 0, 0, nolk);
    chk("all_invalid", victim_way, 0);

    // Same-cycle touch/lookup
    step(1, 1, allv, 1, 1, 0, 0, nolk);
    chk("fwd_same_idx", victim_way, 2);
    step(1, 2, allv, 1, 1, 0, 0, nolk);
    chk("diff_idx", victim_way, 0);

    // Back-to-back lookups
    step(1, 1, allv, 0, 0, 0, 0, nolk);
    step(1, 5, allv, 0, 0, 0, 0, nolk);

    // Flush sweep; lookup in the flush cycle sees the pre-flush tree
    step(0, 0, allv, 1, 7, 0, 0, nolk);
    step(1, 7, allv, 0, 0, 0, 1, nolk);
    chk("lookup_with_flush", victim_way, 2);
    busy_cnt = busy ? 1 : 0;
    for (int k = 0; k < SETS; k++) begin
      if (k == 3) step(1, 0, allv, 1, 0, 0, 1, nolk);
      else        step(0, 0, allv, 0, 0, 0, 0, nolk);
      if (busy) busy_cnt++;
    end
    chk("busy_cycles", busy_cnt, SETS);
    step(1, 7, allv, 0, 0, 0, 0, nolk);
    chk("post_flush_idx7", victim_way, 0);
    step(1, 0, allv, 0, 0, 0, 0, nolk);
    chk("dropped_touch_idx0", victim_way, 0);

    // Async reset in the middle of a sweep
    step(0, 0, allv, 1, 3, 3, 0, nolk);
    step(0, 0, allv, 0, 0, 0, 1, nolk);
    step(0, 0, allv, 0, 0, 0, 0, nolk);
    step(0, 0, allv, 0, 0, 0, 0, nolk);
    idle_inputs();
    rst_n = 1'b0;
    m_clear_all();
    m_rem = 0;
    m_idx = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", lookup_ready, 1);
    chk("abort_victim_valid", victim_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 3, allv, 0, 0, 0, 0, nolk);
    chk("abort_idx3", victim_way, 0);

`ifdef PLRU_WAY_LOCK_EN
    step(1, 4, allv, 0, 0, 0, 0, 4'b0011);
    chk("lock_0011", victim_way, 2);
    step(1, 4, allv, 0, 0, 0, 0, 4'b1111);
    chk("lock_all_none", victim_none, 1);
    chk("lock_all_way", victim_way, 0);
`endif

    // Randomized traffic
    for (int r = 0; r < 400; r++) begin
      bit [WAYS-1:0] v, lk;
      v  = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : allv;
      lk = nolk;
`ifdef PLRU_WAY_LOCK_EN
      if ($urandom_range(0, 3) == 0) lk = WAYS'($urandom);
`endif
      step($urandom_range(0, 1) == 1, $urandom_range(0, SETS - 1), v,
           $urandom_range(0, 1) == 1, $urandom_range(0, SETS - 1),
           $urandom_range(0, WAYS - 1), $urandom_range(0, 39) == 0, lk);
    end

    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
